message_counter_multilane: RTL and testbench
============================================

# message_counter_multilane

Parametrised multi-lane successor to the single-lane DES message counter. Each accepted cycle emits `LANES` consecutive plaintext messages over a valid/ready handshake. Each message is `{counter, region}`: the low `N` bits are a region tag latched at start; the upper `W-N` bits are a running counter from 0 up to a programmable limit. The block sits in front of multiple parallel DES cores and throttles on their backpressure rather than on a pause line.

## Interface
- `W`, 64, message width in bits.
- `N`, 16, region tag width. Legal range 1..W-2.
- `LANES`, 4, messages emitted per transfer. Power of two, 1..16, and ≤ 2^(W-N).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active low.
- `start`  in  1  begin a run. Honoured in IDLE only.
- `clear`  in  1  synchronous abort/rearm. Returns the block to IDLE from any state.
- `region_select`  in  N  region tag. Sampled on accepted `start`.
- `count_limit`  in  W-N  inclusive last counter value. Sampled on accepted `start`.
- `out_valid`  out  1  a batch is presented on `messages`.
- `out_ready`  in  1  downstream accepts the batch.
- `messages`  out  LANES*W  lane i occupies `[i*W +: W]` and carries `{base+i, region}`.
- `lane_valid`  out  LANES  bit i is set iff `base+i <= limit`.
- `base`  out  W-N  counter value of lane 0 (progress indicator).
- `done`  out  1  high once the last batch is accepted. Held until `clear`.

## Operation
- Internal registers:
  - state: IDLE, RUN, DONE.
  - `base_reg`: W-N bits.
  - `region_reg`: N bits.
  - `limit_reg`: W-N bits.
- IDLE:
  - Outputs `out_valid=0`, `done=0`.
  - On `start && !clear`: `base_reg<=0`, `region_reg<=region_select`, `limit_reg<=count_limit`, go to RUN.
- RUN:
  - `out_valid=1`.
  - A transfer occurs when `out_valid && out_ready`.
  - On a transfer with `base_reg + LANES - 1 >= limit_reg`: go to DONE; `base_reg` holds.
  - On any other transfer: `base_reg <= base_reg + LANES`.
  - Without a transfer: all registers hold, and `messages`/`lane_valid` stay stable (AXI-style stability).
- DONE:
  - `out_valid=0`, `done=1`.
  - Stays in DONE until `clear`. `start` is ignored.
- `clear`:
  - Highest priority, from any state.
  - Next state is IDLE and `base_reg<=0`. `region_reg` and `limit_reg` hold.
  - `start` in the same cycle is ignored.
- Arithmetic:
  - `base+i` and the last-batch comparison are computed in W-N+1 bits, so there is no wrap at limit = all ones.
  - The `messages` counter field is the truncated W-N low bits.
- Lane masking:
  - Lanes past the limit in the final batch have `lane_valid=0`.
  - Their message content is don't-care but deterministic, i.e. still `{base+i, region}` truncated.
- `lane_valid` is combinational from `base_reg` and `limit_reg`, gated by `out_valid`. It is all zero outside RUN.

## Timing
- Reset (async, `rst_n=0`):
  - state=IDLE; `base_reg`, `region_reg`, `limit_reg` = 0.
  - `out_valid=0`, `done=0`, `lane_valid=0`, `messages=0`, `base=0`.
- Start latency: `start` sampled at edge k gives `out_valid=1` with `base=0` during cycle k+1.
- Throughput: with `out_ready` held high, one batch per cycle (LANES messages/cycle).
- Done timing: the final transfer at edge k gives `done=1`, `out_valid=0` from cycle k+1.
- Clear timing: `clear` at edge k gives IDLE in cycle k+1. The earliest restart is `start` at edge k+1.
- Reset mid-run: immediate return to reset values. No partial batch is reissued.

## Configuration
- `MSGCNT_LIMIT_EN` defined:
  - `count_limit` port present and behaves as above.
- `MSGCNT_LIMIT_EN` undefined:
  - `count_limit` port is removed.
  - `limit_reg` is constant all ones (full 2^(W-N) range).
  - The final batch always has all lanes valid, since LANES divides 2^(W-N).

## Test plan
- W=64, N=16, LANES=4, limit=9, region=0xBEEF, ready=1:
  - Batches have base 0, 4, 8 with `lane_valid` 1111, 1111, 0011.
  - Lane 1 of batch 2 = 0x0000_0000_0009_BEEF.
  - `done` rises the cycle after the third transfer.
- Backpressure: same config, `out_ready` low for 3 cycles mid-run. Base stays 4 and `messages` stay stable for those cycles; no batch is skipped or duplicated.
- Limit boundary: limit=3 with LANES=4 gives a single batch, mask 1111, then done. Limit=0 gives one batch with mask 0001.
- Macro off, W=20, N=16, LANES=4: 4 batches (bases 0, 4, 8, 12), all masks 1111, no wrap to 0, then done.
- `clear` asserted together with `start` in DONE: the block goes to IDLE and does not start. `start` on the next cycle begins a new run at base 0 with the newly sampled region.
- `rst_n` dropped asynchronously mid-RUN (between clock edges): `out_valid` and `done` go to 0 immediately, and all reset values are checked before the next edge.

Source files
------------

// File: rtl/message_counter_multilane.sv
// message_counter_multilane: emits LANES consecutive {counter, region} messages per valid/ready transfer.
// Define MSGCNT_LIMIT_EN to expose count_limit; otherwise the counter always runs its full range.
module message_counter_multilane #(
    parameter int W     = 64,
    parameter int N     = 16,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [N-1:0]         region_select,
`ifdef MSGCNT_LIMIT_EN
    input  logic [W-N-1:0]       count_limit,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   messages,
    output logic [LANES-1:0]     lane_valid,
    output logic [W-N-1:0]       base,
    output logic                 done
);

    localparam int CW  = W - N;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]   LAST_OFFSET = CW1'(LANES - 1);
    localparam logic [CW-1:0] STEP        = CW'(LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] base_reg;
    logic [CW-1:0] base_next;
    logic [N-1:0]  region_reg;
    logic [N-1:0]  region_next;
    logic [CW-1:0] limit_reg;
    logic          last_batch;

    // One extra bit so a limit of all ones never wraps the comparison.
    assign last_batch = (({1'b0, base_reg} + LAST_OFFSET) >= {1'b0, limit_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_reg   <= '0;
            region_reg <= '0;
        end else begin
            state      <= state_next;
            base_reg   <= base_next;
            region_reg <= region_next;
        end
    end

`ifdef MSGCNT_LIMIT_EN
    logic [CW-1:0] limit_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_reg <= '0;
        end else begin
            limit_reg <= limit_next;
        end
    end
`else
    assign limit_reg = '1;
`endif

    always_comb begin
        state_next  = state;
        base_next   = base_reg;
        region_next = region_reg;
`ifdef MSGCNT_LIMIT_EN
        limit_next  = limit_reg;
`endif
        if (clear) begin
            state_next = IDLE;
            base_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next  = RUN;
                        base_next   = '0;
                        region_next = region_select;
`ifdef MSGCNT_LIMIT_EN
                        limit_next  = count_limit;
`endif
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (last_batch) begin
                            state_next = DONE;
                        end else begin
                            base_next = base_reg + STEP;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == RUN);
    assign done      = (state == DONE);
    assign base      = base_reg;

    // Messages are zeroed outside RUN so the bus is quiet while idle or done.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CW:0] lane_count;

        assign lane_count            = {1'b0, base_reg} + CW1'(i);
        assign messages[i*W +: W]    = out_valid ? {lane_count[CW-1:0], region_reg} : '0;
        assign lane_valid[i]         = out_valid && (lane_count <= {1'b0, limit_reg});
    end

endmodule

// File: tb/tb_message_counter_multilane.sv
// Self-checking bench for message_counter_multilane; a scoreboard of expected batches is
// filled when a run is started and drained by a negedge monitor on each transfer.
module tb_message_counter_multilane;

`ifdef MSGCNT_LIMIT_EN
    localparam int     W          = 64;
    localparam longint RUN_LIMIT  = 9;
    localparam logic [255:0] LAST_LANE1 = 256'h0000_0000_0009_BEEF;
`else
    localparam int     W          = 20;
    localparam longint RUN_LIMIT  = 15;
    localparam logic [255:0] LAST_LANE1 = 256'hD_BEEF;
`endif
    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int CW    = W - N;
    localparam int RUN_BATCHES = int'(RUN_LIMIT / LANES) + 1;

    typedef struct {
        logic [CW-1:0]        base;
        logic [LANES-1:0]     mask;
        logic [LANES*W-1:0]   msgs;
    } batch_t;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 clear;
    logic [N-1:0]         region_select;
`ifdef MSGCNT_LIMIT_EN
    logic [CW-1:0]        count_limit;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   messages;
    logic [LANES-1:0]     lane_valid;
    logic [CW-1:0]        base;
    logic                 done;

    batch_t               sb[$];
    batch_t               front;
    logic [LANES*W-1:0]   lastMsgs;
    int                   testCount = 0;
    int                   failCount = 0;

    message_counter_multilane #(
        .W(W),
        .N(N),
        .LANES(LANES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .clear(clear),
        .region_select(region_select),
`ifdef MSGCNT_LIMIT_EN
        .count_limit(count_limit),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .messages(messages),
        .lane_valid(lane_valid),
        .base(base),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic r,
                                 input logic [N-1:0] region, input longint lim);
        start         = s;
        clear         = c;
        out_ready     = r;
        region_select = region;
`ifdef MSGCNT_LIMIT_EN
        count_limit   = CW'(lim);
`else
        if (lim < 0) start = 1'b0;
`endif
    endtask

    // Reference model: every batch of a run, with its mask and lane contents.
    task automatic pushRun(input logic [N-1:0] region, input longint lim);
        longint b;
        longint v;
        batch_t e;
        b = 0;
        while (1) begin
            e.base = CW'(b);
            for (int i = 0; i < LANES; i++) begin
                v = b + i;
                e.mask[i]          = (v <= lim);
                e.msgs[i*W +: W]   = {v[CW-1:0], region};
            end
            sb.push_back(e);
            if (b + LANES - 1 >= lim) break;
            b = b + LANES;
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("done reached", done, 1'b1);
    endtask

    // Monitor: compare the presented batch against the scoreboard front; pop on transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checkOutput("batch expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                front = sb[0];
                checkOutput("batch base", base, front.base);
                checkOutput("batch lane_valid", lane_valid, front.mask);
                checkOutput("batch messages", messages, front.msgs);
                if (out_ready === 1'b1) begin
                    lastMsgs = messages;
                    sb.delete(0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 0);
        tick(2);
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset lane_valid", lane_valid, '0);
        checkOutput("reset messages", messages, '0);
        checkOutput("reset base", base, '0);
        rst_n = 1'b1;
        tick(1);

        // Nominal run with ready held high, exact done timing.
        pushRun(16'hBEEF, RUN_LIMIT);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hBEEF, RUN_LIMIT);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, RUN_LIMIT);
        checkOutput("start latency out_valid", out_valid, 1'b1);
        checkOutput("start latency base", base, '0);
        tick(RUN_BATCHES - 1);
        checkOutput("before last out_valid", out_valid, 1'b1);
        checkOutput("before last done", done, 1'b0);
        tick(1);
        checkOutput("done after last", done, 1'b1);
        checkOutput("out_valid after last", out_valid, 1'b0);
        checkOutput("lane_valid after last", lane_valid, '0);
        checkOutput("scoreboard drained", sb.size(), 0);
        checkOutput("last batch lane1", lastMsgs[W +: W], LAST_LANE1);

        // Start in DONE is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1111, RUN_LIMIT);
        tick(2);
        checkOutput("done held", done, 1'b1);
        checkOutput("done ignores start", out_valid, 1'b0);

        // Clear with start in DONE goes to IDLE without starting.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222, RUN_LIMIT);
        tick(1);
        checkOutput("clear idle out_valid", out_valid, 1'b0);
        checkOutput("clear idle done", done, 1'b0);
        checkOutput("clear idle base", base, '0);

        // Restart with a new region, then backpressure for three cycles.
        pushRun(16'h1234, RUN_LIMIT);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, RUN_LIMIT);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, RUN_LIMIT);
        checkOutput("restart base", base, '0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, RUN_LIMIT);
        checkOutput("stall entry base", base, CW'(4));
        tick(3);
        checkOutput("stall held base", base, CW'(4));
        checkOutput("stall out_valid", out_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, RUN_LIMIT);
        waitDone(20);
        checkOutput("backpressure drained", sb.size(), 0);

`ifdef MSGCNT_LIMIT_EN
        // Limit boundaries: exactly one batch, and a single valid lane.
        applyStimulus(1'b0, 1'b1, 1'b1, '0, 0);
        tick(1);
        pushRun(16'h0303, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0303, 3);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0303, 3);
        checkOutput("limit3 mask", lane_valid, 4'b1111);
        tick(1);
        checkOutput("limit3 done", done, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b1, '0, 0);
        tick(1);
        pushRun(16'h0000, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
        checkOutput("limit0 mask", lane_valid, 4'b0001);
        tick(1);
        checkOutput("limit0 done", done, 1'b1);
        checkOutput("limits drained", sb.size(), 0);
`endif

        // Asynchronous reset between edges while a run is stalled.
        applyStimulus(1'b0, 1'b1, 1'b0, '0, RUN_LIMIT);
        tick(1);
        pushRun(16'h5555, RUN_LIMIT);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h5555, RUN_LIMIT);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h5555, RUN_LIMIT);
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", out_valid, 1'b0);
        checkOutput("async reset done", done, 1'b0);
        checkOutput("async reset lane_valid", lane_valid, '0);
        checkOutput("async reset messages", messages, '0);
        checkOutput("async reset base", base, '0);
        sb.delete();
        tick(1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, '0, RUN_LIMIT);
        tick(1);
        checkOutput("no reissue after reset", out_valid, 1'b0);

        // Fresh run after reset completes normally.
        pushRun(16'hA5A5, RUN_LIMIT);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hA5A5, RUN_LIMIT);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hA5A5, RUN_LIMIT);
        waitDone(20);
        checkOutput("final drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
